// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with a receive FIFO.
// Supports 5..DATA_W data bits, optional even/odd parity, 1 or 2 stop bits and
// break detection. Each character is stored in the FIFO together with its error
// flags, and the FIFO is drained through a valid/ready handshake.
// Build option: define UART_RX_MAJORITY_VOTE_EN to take every sample as a 2-of-3
// vote around the sample point. This adds one clock to the commit latency.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line idle; a low level starts the half-bit start check
// START   | waiting for mid start bit; a high sample there is a false start
// DATA    | one sample per bit period, LSB first
// PARITY  | sample the parity bit
// STOP1   | sample the first stop bit; commit unless a second stop bit follows
// STOP2   | sample the second stop bit and commit
// WAIT    | after a framing error, hold until the line returns high
module uart_rx_cfg #(
    parameter int DATA_W     = 8,
    parameter int BAUD_DIV_W = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx_pin_in,
    input  logic [BAUD_DIV_W-1:0]             baud_div_i,
    input  logic [$clog2(DATA_W+1)-1:0]       data_bits_i,
    input  logic                              parity_en_i,
    input  logic                              parity_odd_i,
    input  logic                              stop2_i,
    output logic [DATA_W-1:0]                 rx_data_o,
    output logic                              rx_frame_err_o,
    output logic                              rx_parity_err_o,
    output logic                              rx_break_o,
    output logic                              rx_valid_o,
    input  logic                              rx_ready_i,
    output logic                              overrun_o,
    input  logic                              err_clr_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count_o,
    output logic                              busy_o
);

    localparam int DBW = $clog2(DATA_W + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int EW  = DATA_W + 3;
    localparam logic [DBW-1:0] DW_L  = DBW'(DATA_W);
    localparam logic [CW-1:0]  FULL_L = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT
    } state_t;

    state_t st, st_n;

    logic                  sync1, line;
    logic [BAUD_DIV_W-1:0] cnt;
    logic                  smp_evt, smp_val;

    logic [DBW-1:0]    nbits_eff, nbits_q, bit_idx;
    logic              par_en_q, par_odd_q, stop2_q;
    logic [DATA_W-1:0] data_sr;
    logic              par_acc, par_bit_q, par_err_q;

    logic cfg_ld, shift_en, par_ld, push, p_frame, p_break, p_par;
    logic [EW-1:0] push_entry;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, push_ok, drop;
    logic [EW-1:0] head;

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= rx_pin_in;
            line  <= sync1;
        end
    end

    // Bit timer: half-bit load on a start edge, otherwise reload at terminal count.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (st == S_IDLE && !line)
            cnt <= baud_div_i >> 1;
        else if (cnt == '0)
            cnt <= baud_div_i - 1'b1;
        else
            cnt <= cnt - 1'b1;
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic smp_m1, smp_0, evt_q;

    // Capture the line around the sample point; the vote resolves one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_m1 <= 1'b1;
            smp_0  <= 1'b1;
            evt_q  <= 1'b0;
        end else begin
            if (cnt == BAUD_DIV_W'(1))
                smp_m1 <= line;
            if (cnt == '0)
                smp_0 <= line;
            evt_q <= (cnt == '0) && (st != S_IDLE) && (st != S_WAIT);
        end
    end

    assign smp_evt = evt_q;
    assign smp_val = (smp_m1 & smp_0) | (smp_m1 & line) | (smp_0 & line);
`else
    assign smp_evt = (cnt == '0) && (st != S_IDLE) && (st != S_WAIT);
    assign smp_val = line;
`endif

    // Out-of-range data lengths fall back to the maximum width.
    assign nbits_eff = (data_bits_i < DBW'(5) || data_bits_i > DW_L) ? DW_L : data_bits_i;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            st <= S_IDLE;
        else
            st <= st_n;
    end

    // FSM next state and per-cycle datapath strobes.
    always_comb begin
        st_n     = st;
        cfg_ld   = 1'b0;
        shift_en = 1'b0;
        par_ld   = 1'b0;
        push     = 1'b0;
        p_frame  = 1'b0;
        p_break  = 1'b0;
        p_par    = 1'b0;
        case (st)
            S_IDLE: begin
                if (!line)
                    st_n = S_START;
            end
            S_START: begin
                if (smp_evt) begin
                    if (!smp_val) begin
                        cfg_ld = 1'b1;
                        st_n   = S_DATA;
                    end else begin
                        st_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (smp_evt) begin
                    shift_en = 1'b1;
                    if (bit_idx == nbits_q - 1'b1)
                        st_n = par_en_q ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (smp_evt) begin
                    par_ld = 1'b1;
                    st_n   = S_STOP1;
                end
            end
            S_STOP1: begin
                if (smp_evt) begin
                    if (stop2_q && smp_val) begin
                        st_n = S_STOP2;
                    end else begin
                        push    = 1'b1;
                        p_frame = !smp_val;
                        p_break = !smp_val && (data_sr == '0) && !(par_en_q && par_bit_q);
                        p_par   = par_err_q;
                        st_n    = smp_val ? S_IDLE : S_WAIT;
                    end
                end
            end
            S_STOP2: begin
                if (smp_evt) begin
                    push    = 1'b1;
                    p_frame = !smp_val;
                    p_par   = par_err_q;
                    st_n    = smp_val ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (line)
                    st_n = S_IDLE;
            end
            default: st_n = S_IDLE;
        endcase
    end

    // Frame datapath: config shadows, data shift register and parity tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            nbits_q   <= DW_L;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            data_sr   <= '0;
            bit_idx   <= '0;
            par_acc   <= 1'b0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (cfg_ld) begin
                nbits_q   <= nbits_eff;
                par_en_q  <= parity_en_i;
                par_odd_q <= parity_odd_i;
                stop2_q   <= stop2_i;
                data_sr   <= '0;
                bit_idx   <= '0;
                par_acc   <= 1'b0;
                par_bit_q <= 1'b0;
                par_err_q <= 1'b0;
            end
            if (shift_en) begin
                data_sr <= {smp_val, data_sr[DATA_W-1:1]};
                par_acc <= par_acc ^ smp_val;
                bit_idx <= bit_idx + 1'b1;
            end
            if (par_ld) begin
                par_bit_q <= smp_val;
                par_err_q <= (par_acc ^ smp_val) != par_odd_q;
            end
        end
    end

    // Short characters arrive in the top bits of the shifter; right-justify them.
    assign push_entry = {p_break, p_par, p_frame, data_sr >> (DW_L - nbits_q)};

    assign full    = (count == FULL_L);
    assign pop     = rx_valid_o && rx_ready_i;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Receive FIFO storage, pointers, occupancy and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_o <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (pop && !push_ok)
                count <= count - 1'b1;
            if (drop)
                overrun_o <= 1'b1;
            else if (err_clr_i)
                overrun_o <= 1'b0;
        end
    end

    assign head            = mem[rd_ptr];
    assign rx_data_o       = head[DATA_W-1:0];
    assign rx_frame_err_o  = head[DATA_W];
    assign rx_parity_err_o = head[DATA_W+1];
    assign rx_break_o      = head[DATA_W+2];
    assign rx_valid_o      = (count != '0);
    assign fifo_count_o    = count;
    assign busy_o          = (st != S_IDLE);

endmodule
